// File: rtl/div32x16_seq.sv
// Sequential restoring divider: N_WIDTH-bit dividend / D_WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (truncating toward zero, remainder takes the dividend's sign).
module div32x16_seq #(
    parameter int N_WIDTH = 32,
    parameter int D_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_a,
    input  logic               start,
    input  logic [N_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [N_WIDTH-1:0] quotient_out,
    output logic [D_WIDTH-1:0] remainder_out,
    output logic               done_flag,
    output logic               div_by_zero,
    output logic [3:0]         state_out
);

    localparam int CW = $clog2(N_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [N_WIDTH-1:0] dvd_sr;
    logic [D_WIDTH-1:0] dvs;
    logic [D_WIDTH:0]   prem;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               last;
    logic [N_WIDTH-1:0] cap_dvd;
    logic [D_WIDTH-1:0] cap_dvs;
    logic [D_WIDTH+1:0] shifted;
    logic [D_WIDTH+1:0] diff;
    logic               ge;
    logic [D_WIDTH:0]   prem_next;
    logic [N_WIDTH-1:0] q_raw;
    logic [N_WIDTH-1:0] q_fin;
    logic [D_WIDTH-1:0] r_fin;

    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign last      = (cnt == CW'(N_WIDTH - 1));
    assign state_out = {2'b00, state};

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;

    // The core always works on magnitudes; signs are reapplied on the way out.
    assign cap_dvd = dividend[N_WIDTH-1] ? -dividend : dividend;
    assign cap_dvs = divisor[D_WIDTH-1]  ? -divisor  : divisor;
    assign q_fin   = neg_q ? -q_raw : q_raw;
    assign r_fin   = neg_r ? -prem_next[D_WIDTH-1:0] : prem_next[D_WIDTH-1:0];
`else
    assign cap_dvd = dividend;
    assign cap_dvs = divisor;
    assign q_fin   = q_raw;
    assign r_fin   = prem_next[D_WIDTH-1:0];
`endif

    // One restoring step: a negative trial difference leaves the shifted remainder untouched.
    assign shifted   = {prem, dvd_sr[N_WIDTH-1]};
    assign diff      = shifted - {2'b00, dvs};
    assign ge        = ~diff[D_WIDTH+1];
    assign prem_next = ge ? diff[D_WIDTH:0] : shifted[D_WIDTH:0];
    assign q_raw     = {dvd_sr[N_WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = (divisor == '0) ? DONE : BUSY;
            BUSY:       if (last)  state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // The dividend shift register doubles as the quotient accumulator.
    always_ff @(posedge clk or negedge reset_a) begin
        if (!reset_a) begin
            dvd_sr        <= '0;
            dvs           <= '0;
            prem          <= '0;
            cnt           <= '0;
            quotient_out  <= '0;
            remainder_out <= '0;
            done_flag     <= 1'b0;
            div_by_zero   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
`endif
        end else if (accept) begin
            dvd_sr      <= cap_dvd;
            dvs         <= cap_dvs;
            prem        <= '0;
            cnt         <= '0;
            done_flag   <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= dividend[N_WIDTH-1] ^ divisor[D_WIDTH-1];
            neg_r       <= dividend[N_WIDTH-1];
`endif
            if (divisor == '0) begin
                quotient_out  <= '1;
                remainder_out <= dividend[D_WIDTH-1:0];
                div_by_zero   <= 1'b1;
                done_flag     <= 1'b1;
            end
        end else if (state == BUSY) begin
            dvd_sr <= q_raw;
            prem   <= prem_next;
            cnt    <= cnt + CW'(1);
            if (last) begin
                quotient_out  <= q_fin;
                remainder_out <= r_fin;
                done_flag     <= 1'b1;
            end
        end
    end

endmodule

// File: doc/div32x16_seq.md
Name: div32x16_seq

Overview:
- Sequential restoring divider: 32-bit dividend ÷ 16-bit divisor, producing a 32-bit quotient and a 16-bit remainder.
- Resolves one quotient bit per clock.
- Inverse datapath companion to the 16x16 multiplier in the ALU. It uses the same start / done_flag handshake and the same 4-bit state_out feed to the seven-segment controller, so the two blocks can share control and display wiring.

Parameters:
N_WIDTH, 32, dividend and quotient width; iteration count equals N_WIDTH
D_WIDTH, 16, divisor and remainder width

Ports:
clk  input  1  rising-edge clock
reset_a  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE or DONE
dividend  input  N_WIDTH  numerator
divisor  input  D_WIDTH  denominator
quotient_out  output  N_WIDTH  quotient result
remainder_out  output  D_WIDTH  remainder result
done_flag  output  1  high while in DONE
div_by_zero  output  1  high in DONE when the captured divisor was 0
state_out  output  4  current state code for seven_segment_cntrl

Behaviour:
- Reset (reset_a=0, asynchronous):
  - State goes to IDLE.
  - quotient_out, remainder_out, the internal partial remainder and the cycle counter all clear to 0.
  - done_flag=0, div_by_zero=0, state_out=4'd0.
  - Reset asserted mid-operation aborts the division immediately; nothing of it is retained.
- State codes on state_out: IDLE=0, BUSY=1, DONE=2. No other code is ever driven.
- IDLE/DONE with start=1 at a clock edge:
  - Capture dividend and divisor into internal registers.
  - Clear the partial remainder (D_WIDTH+1 bits) and the counter.
  - Clear done_flag and div_by_zero.
  - If the captured divisor==0, go directly to DONE on that edge: quotient_out=all ones, remainder_out=dividend[D_WIDTH-1:0], div_by_zero=1.
  - Otherwise go to BUSY.
- BUSY, each edge:
  - Shift the MSB of the dividend shift-register into the partial remainder.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; else restore and shift in 0.
  - Counter increments.
  - After the N_WIDTH-th BUSY edge, load quotient_out and remainder_out and go to DONE.
- Latency: start captured at edge k → done_flag first high after edge k+N_WIDTH (k+32 at defaults). Divide-by-zero case → done_flag high after edge k.
- DONE:
  - Outputs and done_flag hold until the next accepted start.
  - start=0 holds in DONE indefinitely.
- start while BUSY is ignored; operand changes during BUSY have no effect.
- start held continuously high restarts on every DONE exit. done_flag is high for exactly one cycle per operation in that case.
- Arithmetic:
  - Unsigned by default.
  - Remainder is always < divisor.
  - quotient×divisor+remainder == dividend holds for every non-zero divisor.
  - The partial remainder is D_WIDTH+1 bits wide so the trial subtract never overflows.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - On capture, magnitudes are taken and the result signs are recorded.
  - Quotient is negated if the operand signs differ; truncation is toward zero.
  - Remainder takes the dividend's sign.
  - Sign fix-up is applied when loading outputs at the BUSY→DONE transition; latency is unchanged.
  - -2^31 ÷ -1 wraps to 32'h80000000 with no flag.
  - Divide-by-zero behaves as unsigned: quotient all ones, remainder = dividend low bits.
- Undefined: purely unsigned; no sign logic is synthesized.
- Ports are identical in both builds.

Test Plan:
- Reset, then dividend=100, divisor=7, start pulsed one cycle → done_flag rises 32 edges after capture; quotient_out=14, remainder_out=2, div_by_zero=0, state_out sequence 0→1→2.
- dividend=32'hFFFFFFFF, divisor=16'hFFFF → quotient_out=32'h00010001, remainder_out=0; dividend=5, divisor=9 → quotient_out=0, remainder_out=5.
- dividend=32'h12345678, divisor=0 → DONE one edge after capture; quotient_out=32'hFFFFFFFF, remainder_out=16'h5678, div_by_zero=1.
- Start 100/7; at BUSY cycle 10, change operands to 50/5 and pulse start → ignored, result still 14 r 2. Then start 50/5 from DONE → quotient_out=10, remainder_out=0, done_flag low during BUSY.
- reset_a driven low at BUSY cycle 20 → all outputs 0 and state_out=0 immediately, without waiting for a clock; a new 1000/3 run completes with quotient_out=333, remainder_out=1.
- DIV_SIGNED_EN: -100/7 → quotient_out=32'hFFFFFFF2, remainder_out=16'hFFFE; 100/-7 → quotient_out=32'hFFFFFFF2, remainder_out=2; -2^31/-1 → quotient_out=32'h80000000, remainder_out=0.
